// File: rtl/timer_divider_pkg.sv
// Shared constants for the dual-channel timer/divider: bus addresses,
// control-word bit positions and the channel output mode.
package timer_pkg;

    localparam logic [1:0] ADDR_DIV0 = 2'b00;
    localparam logic [1:0] ADDR_DIV1 = 2'b01;
    localparam logic [1:0] ADDR_CTRL = 2'b10;
    localparam logic [1:0] ADDR_IDLE = 2'b11;

    localparam int CTRL_MODE0   = 0;
    localparam int CTRL_MODE1   = 1;
    localparam int CTRL_RESTART = 2;
    localparam int CTRL_CASCADE = 3;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } timer_mode_e;

endpackage

// File: rtl/timer_divider_channel.sv
// One divider channel: divisor register, down-counter and registered output.
// The adv input lets the top chain this channel behind another one.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] data,
    input  timer_mode_e      mode,
    input  logic             mode_wr,
    input  timer_mode_e      mode_in,
    input  logic             restart,
    input  logic             gate,
    input  logic             adv,
    output logic             out,
    output logic             term
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] reload;
    logic             out_next;

    assign term = (div != '0) && (cnt == '0);

    // A zero divisor (current or being written) parks the channel; a write to a
    // parked channel starts it, otherwise restart beats normal gated counting.
    always_comb begin
        cnt_next = cnt;
        out_next = out;
        reload   = wr ? data : div;
        if ((wr && data == '0) || (!wr && div == '0)) begin
            cnt_next = '0;
            out_next = 1'b0;
        end else if (wr && div == '0) begin
            cnt_next = data - ONE;
        end else if (restart) begin
            cnt_next = div - ONE;
            out_next = 1'b0;
        end else begin
            if (gate && adv) begin
                if (cnt != '0) begin
                    cnt_next = cnt - ONE;
                    if (mode == MODE_PULSE)
                        out_next = 1'b0;
                end else begin
                    cnt_next = reload - ONE;
                    out_next = (mode == MODE_PULSE) ? 1'b1 : ~out;
                end
            end
            if (mode_wr && mode_in != mode)
                out_next = (mode_in == MODE_PULSE) ? 1'b0 : out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            cnt <= '0;
            out <= 1'b0;
        end else begin
            if (wr)
                div <= data;
            cnt <= cnt_next;
            out <= out_next;
        end
    end

endmodule

// File: rtl/timer_divider.sv
// Dual-channel programmable divider: address decode and control register.
// Define TIMER_DIVIDER_CASCADE_EN to let channel 1 count channel 0 terminals.
module timer_divider
    import timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       a,
    input  logic             g0,
    input  logic             g1,
    output logic             out0,
    output logic             out1
);

    logic        wr0;
    logic        wr1;
    logic        ctrl_wr;
    logic        restart;
    logic        adv1;
    logic        term0;
    logic        term1;
    logic        unused_term;
    timer_mode_e mode0;
    timer_mode_e mode1;

    always_comb begin
        wr0     = 1'b0;
        wr1     = 1'b0;
        ctrl_wr = 1'b0;
        case (a)
            ADDR_DIV0: wr0     = 1'b1;
            ADDR_DIV1: wr1     = 1'b1;
            ADDR_CTRL: ctrl_wr = 1'b1;
            ADDR_IDLE: ;
            default:   ;
        endcase
    end

    assign restart = ctrl_wr && d[CTRL_RESTART];

`ifdef TIMER_DIVIDER_CASCADE_EN
    logic cascade;
`endif

    // Restart is a strobe derived from the bus and is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode0 <= MODE_SQUARE;
            mode1 <= MODE_SQUARE;
`ifdef TIMER_DIVIDER_CASCADE_EN
            cascade <= 1'b0;
`endif
        end else if (ctrl_wr) begin
            mode0 <= timer_mode_e'(d[CTRL_MODE0]);
            mode1 <= timer_mode_e'(d[CTRL_MODE1]);
`ifdef TIMER_DIVIDER_CASCADE_EN
            cascade <= d[CTRL_CASCADE];
`endif
        end
    end

`ifdef TIMER_DIVIDER_CASCADE_EN
    assign adv1        = cascade ? (term0 && g0) : 1'b1;
    assign unused_term = term1;
`else
    assign adv1        = 1'b1;
    assign unused_term = term0 ^ term1;
`endif

    timer_channel #(.WIDTH(WIDTH)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr0),
        .data    (d),
        .mode    (mode0),
        .mode_wr (ctrl_wr),
        .mode_in (timer_mode_e'(d[CTRL_MODE0])),
        .restart (restart),
        .gate    (g0),
        .adv     (1'b1),
        .out     (out0),
        .term    (term0)
    );

    timer_channel #(.WIDTH(WIDTH)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr1),
        .data    (d),
        .mode    (mode1),
        .mode_wr (ctrl_wr),
        .mode_in (timer_mode_e'(d[CTRL_MODE1])),
        .restart (restart),
        .gate    (g1),
        .adv     (adv1),
        .out     (out1),
        .term    (term1)
    );

endmodule

// File: tb/tb_timer_divider.sv
// Self-checking bench for timer_divider: per-cycle vector tables feeding a
// scoreboard, plus hand-written async-reset and out1-period sequences.
module tb_timer_divider;

    import timer_pkg::*;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d;
    logic [1:0]       a;
    logic             g0;
    logic             g1;
    logic             out0;
    logic             out1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0]       a;
        logic [WIDTH-1:0] d;
        logic             g0;
        logic             g1;
        logic             exp0;
        logic             exp1;
    } vec_t;

    typedef struct {
        logic exp0;
        logic exp1;
        int   idx;
    } sb_t;

    vec_t  vecs[$];
    sb_t   sb[$];
    string scen;

    timer_divider #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .a    (a),
        .g0   (g0),
        .g1   (g1),
        .out0 (out0),
        .out1 (out1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic [1:0] va, input logic [WIDTH-1:0] vd,
                                   input logic vg0, input logic vg1,
                                   input logic e0, input logic e1);
        vec_t v;
        v.a = va; v.d = vd; v.g0 = vg0; v.g1 = vg1; v.exp0 = e0; v.exp1 = e1;
        vecs.push_back(v);
    endfunction

    // Drive one cycle's inputs, queue its expectation, compare after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t e;
        a  = v.a;
        d  = v.d;
        g0 = v.g0;
        g1 = v.g1;
        e.exp0 = v.exp0;
        e.exp1 = v.exp1;
        e.idx  = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput($sformatf("%s v%0d out0", scen, e.idx), {31'd0, out0}, {31'd0, e.exp0});
        checkOutput($sformatf("%s v%0d out1", scen, e.idx), {31'd0, out1}, {31'd0, e.exp1});
    endtask

    task automatic runVectors();
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);
        vecs.delete();
        a = ADDR_IDLE;
        d = '0;
    endtask

    task automatic doReset();
        a   = ADDR_IDLE;
        d   = '0;
        g0  = 1'b0;
        g1  = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput({scen, " reset out0"}, {31'd0, out0}, 32'd0);
        checkOutput({scen, " reset out1"}, {31'd0, out1}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [20:0] c_exp;
        logic        prev1;
        int          s;
        int          rises[$];
        int          exp_period;

        rst = 1'b0;
        a   = ADDR_IDLE;
        d   = '0;
        g0  = 1'b0;
        g1  = 1'b0;
        #2;

        // Square wave on channel 0, DIV=4: toggles every 4 edges after the write.
        scen = "sq4";
        doReset();
        addVec(ADDR_DIV0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++)
            addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b0, ((k / 4) % 2) == 1, 1'b0);
        runVectors();

        // Pulse mode on channel 1, DIV=3, gate dropped for 5 cycles right after a pulse.
        scen = "pulse3";
        doReset();
        addVec(ADDR_DIV1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_CTRL, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        s     = 0;
        prev1 = 1'b0;
        for (int k = 2; k < 18; k++) begin
            logic gate;
            gate = !(k >= 7 && k <= 11);
            if (gate) begin
                s++;
                prev1 = (s % 3) == 2;
            end
            addVec(ADDR_IDLE, 4'd0, 1'b0, gate, 1'b0, prev1);
        end
        runVectors();

        // Running DIV0 rewrites: mid-count (4->2) then on a terminal edge (2->3).
        scen  = "rewrite";
        c_exp = 21'b1_000_111_00_11_00_1111_0000;
        doReset();
        for (int k = 0; k < 21; k++) begin
            if (k == 0)
                addVec(ADDR_DIV0, 4'd4, 1'b1, 1'b0, c_exp[k], 1'b0);
            else if (k == 6)
                addVec(ADDR_DIV0, 4'd2, 1'b1, 1'b0, c_exp[k], 1'b0);
            else if (k == 14)
                addVec(ADDR_DIV0, 4'd3, 1'b1, 1'b0, c_exp[k], 1'b0);
            else
                addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b0, c_exp[k], 1'b0);
        end
        runVectors();

        // Restart with both channels running and both outputs high.
        scen = "restart";
        doReset();
        addVec(ADDR_DIV0, 4'd4,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_DIV1, 4'd3,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b1);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b1);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b1);
        addVec(ADDR_CTRL, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b0, 1'b1);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b1);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b1);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b0);
        addVec(ADDR_IDLE, 4'd0,    1'b1, 1'b1, 1'b1, 1'b0);
        runVectors();

        // Asynchronous reset between edges while out0 is high, then DIVs must be 0.
        g0 = 1'b1;
        g1 = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async rst out0", {31'd0, out0}, 32'd0);
        checkOutput("async rst out1", {31'd0, out1}, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        scen = "post_rst";
        for (int k = 0; k < 8; k++)
            addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        runVectors();

        // Writing DIV0=0 while out0 is high stops the channel.
        scen = "stop";
        doReset();
        addVec(ADDR_DIV0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        addVec(ADDR_DIV0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 4; k < 10; k++)
            addVec(ADDR_IDLE, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        runVectors();

        // out1 period with DIV0=2, DIV1=3 and the cascade control bit set.
        scen = "cascade";
        doReset();
`ifdef TIMER_DIVIDER_CASCADE_EN
        exp_period = 12;
`else
        exp_period = 6;
`endif
        g0 = 1'b1;
        g1 = 1'b1;
        a  = ADDR_DIV0; d = 4'd2;
        @(posedge clk); #1;
        a  = ADDR_DIV1; d = 4'd3;
        @(posedge clk); #1;
        a  = ADDR_CTRL; d = 4'b1000;
        @(posedge clk); #1;
        a  = ADDR_IDLE; d = '0;
        prev1 = out1;
        for (int c = 0; c < 80 && rises.size() < 3; c++) begin
            @(posedge clk); #1;
            if (out1 && !prev1)
                rises.push_back(c);
            prev1 = out1;
        end
        checkOutput("cascade out1 rising edges seen", rises.size(), 32'd3);
        if (rises.size() == 3) begin
            checkOutput("cascade out1 period 1", rises[1] - rises[0], exp_period);
            checkOutput("cascade out1 period 2", rises[2] - rises[1], exp_period);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/timer_divider.md
Name: timer_divider

Overview:
- Dual-channel programmable clock divider; the responder side of the timer bus (d/a/g0/g1 in, out0/out1 out) that the bench driver programs.
- Each channel holds a divisor register and a down-counter, and generates a square wave or a one-clock pulse train on its out pin.
- Counting is qualified by the per-channel gate input.
- Sits directly behind the timer bus interface as the DUT of the timer environment.

Parameters:
- WIDTH, 4, width of data bus d, divisor registers and counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- d  input  WIDTH  write data
- a  input  2  register address; 2'b11 = idle (no write)
- g0  input  1  gate for channel 0; high = count, low = hold
- g1  input  1  gate for channel 1
- out0  output  1  channel 0 divided output (registered)
- out1  output  1  channel 1 divided output (registered)

Behaviour:
- Reset is asynchronous and active-high, one clock clk.
  - On rst: DIV0 = DIV1 = 0, cnt0 = cnt1 = 0, mode0 = mode1 = square, cascade = 0, out0 = out1 = 0.
- Writes: no strobe. The address is decoded every edge.
  - a=00: DIV0 <= d.
  - a=01: DIV1 <= d.
  - a=10: control write.
  - a=11: no-op. The driver parks here when idle.
- Control word:
  - d[0] = mode0 (0 square, 1 pulse).
  - d[1] = mode1.
  - d[2] = restart: self-clearing, not stored.
  - d[3] = cascade (see Optional Feature).
- Restart: at the same edge, both counters load DIV-1 and both outs clear to 0, regardless of gates.
- Channel n, per rising edge:
  - DIVn == 0: channel stopped; cnt <= 0, out <= 0; the gate is ignored.
  - Gate low: cnt and out hold their values.
  - Gate high, cnt != 0: cnt <= cnt-1.
  - Gate high, cnt == 0 (terminal): cnt <= DIVn-1.
    - Square mode: out toggles.
    - Pulse mode: out <= 1 for exactly one cycle, else out <= 0.
- Period:
  - Square mode period = 2*DIV clocks while the gate is high.
  - Pulse mode gives one pulse every DIV clocks. DIV=1 in pulse mode holds out high continuously.
- Starting a channel: a write to a stopped channel (old DIV = 0) loads cnt <= d-1 at the write edge.
  - The first terminal falls DIV gated edges later.
- Running writes: a new nonzero DIV while running does not disturb cnt; it takes effect at the next terminal reload.
- Write on a terminal edge: the write and the terminal happen at the same edge, and the reload uses the newly written value.
- Mode change: takes effect next edge. Switching to pulse forces out <= 0 at the write edge; switching to square keeps out's current value.
- Gate sampling: the gate is sampled synchronously at the edge. No edge detection or retriggering.
- Reset mid-count: everything returns to reset values immediately. Outputs are low until reprogrammed.

Optional Feature:
- Macro: TIMER_DIVIDER_CASCADE_EN.
- Defined:
  - Control bit d[3] is stored as cascade.
  - When cascade = 1, channel 1 decrements/terminates only on edges where channel 0 is at terminal with g0 high, and g1 is also high. Effective divide = DIV0*DIV1.
  - Restart also resets the channel 0/channel 1 alignment.
- Undefined:
  - d[3] is ignored, cascade is tied 0.
  - Channel 1 advances every gated clk.

Decomposition:
- Package timer_pkg:
  - Address localparams ADDR_DIV0 = 2'b00, ADDR_DIV1 = 2'b01, ADDR_CTRL = 2'b10, ADDR_IDLE = 2'b11.
  - Control bit index constants CTRL_MODE0 = 0, CTRL_MODE1 = 1, CTRL_RESTART = 2, CTRL_CASCADE = 3.
  - Mode enum timer_mode_e {MODE_SQUARE, MODE_PULSE}.
- Sub-module timer_channel: divisor register, counter, out logic; instantiated twice.
  - Inputs: write-enable, data, mode, restart, gate, advance-enable (cascade hook).
  - Output: terminal flag.
- timer_divider itself holds only the address decode and the control register.

Test Plan:
1. Reset, then write a=00 d=4, park a=11, g0=1 -> out0 toggles at edges 4, 8, 12 after the write (period 8); out1 stays 0.
2. DIV1=3, mode1=pulse (ctrl d=4'b0010), g1=1 -> out1 is one-cycle high every 3 clocks. Drop g1 for 5 cycles mid-count -> out1 and cnt freeze, then resume with the same phase.
3. Channel 0 running DIV=4; write DIV0=2 on an edge where cnt0=2 -> next toggle is at the old terminal; subsequent period is 4. Repeat with the write landing on the terminal edge -> the new value is used immediately.
4. Running both channels, write ctrl d=4'b0100 -> both outs are 0 the next cycle and both counters restart aligned. Assert rst mid-count -> outs go 0 asynchronously; DIV0=DIV1=0.
5. Write DIV0=0 while running -> out0 is 0 the next edge and stays 0 with g0=1.
6. With TIMER_DIVIDER_CASCADE_EN: DIV0=2, DIV1=3, ctrl d=4'b1000, g0=g1=1 -> out1 square period = 12 clocks. Without the macro, the same stimulus gives out1 period 6.
